// File: rtl/icache_pkg.sv
// Shared types and width helpers for the direct-mapped instruction cache.
// Optional statistics counters are enabled with the ICACHE_STATS_EN macro.
package icache_pkg;

    // Cache controller states.
    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        REFILL = 1'b1
    } state_e;

    // Number of word-offset bits inside one line.
    function automatic int off_bits(input int words_per_line);
        return $clog2(words_per_line);
    endfunction

    // Number of line-index bits.
    function automatic int idx_bits(input int num_lines);
        return $clog2(num_lines);
    endfunction

    // Tag width: everything above index, word offset and the two byte bits.
    function automatic int tag_bits(input int addr_width, input int num_lines,
                                    input int words_per_line);
        return addr_width - idx_bits(num_lines) - off_bits(words_per_line) - 2;
    endfunction

    // Default geometry, used for the address-split view below.
    localparam int DEF_ADDR_WIDTH     = 32;
    localparam int DEF_NUM_LINES      = 16;
    localparam int DEF_WORDS_PER_LINE = 4;
    localparam int DEF_OFF_BITS       = off_bits(DEF_WORDS_PER_LINE);
    localparam int DEF_IDX_BITS       = idx_bits(DEF_NUM_LINES);
    localparam int DEF_TAG_BITS       = tag_bits(DEF_ADDR_WIDTH, DEF_NUM_LINES,
                                                 DEF_WORDS_PER_LINE);

    // Fetch address viewed as {tag, index, word offset, byte offset}.
    typedef struct packed {
        logic [DEF_TAG_BITS-1:0] tag;
        logic [DEF_IDX_BITS-1:0] idx;
        logic [DEF_OFF_BITS-1:0] off;
        logic [1:0]              byte_off;
    } addr_split_t;

endpackage

// File: rtl/icache_data_ram.sv
// Instruction data store: NUM_LINES x WORDS_PER_LINE words, asynchronous
// read for same-cycle hits, synchronous single-word write for refill beats.
// Contents are not reset; line validity is tracked by the parent.
module icache_data_ram
    import icache_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_LINES      = 16,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic                                clk,
    input  logic                                i_we,
    input  logic [idx_bits(NUM_LINES)-1:0]      i_wr_line,
    input  logic [off_bits(WORDS_PER_LINE)-1:0] i_wr_word,
    input  logic [DATA_WIDTH-1:0]               i_wr_data,
    input  logic [idx_bits(NUM_LINES)-1:0]      i_rd_line,
    input  logic [off_bits(WORDS_PER_LINE)-1:0] i_rd_word,
    output logic [DATA_WIDTH-1:0]               o_rd_data
);

    localparam int IDX_BITS = idx_bits(NUM_LINES);
    localparam int OFF_BITS = off_bits(WORDS_PER_LINE);
    localparam int DEPTH    = NUM_LINES * WORDS_PER_LINE;

    logic [DATA_WIDTH-1:0]        r_mem [DEPTH];
    logic [IDX_BITS+OFF_BITS-1:0] w_wr_addr;
    logic [IDX_BITS+OFF_BITS-1:0] w_rd_addr;

    assign w_wr_addr = {i_wr_line, i_wr_word};
    assign w_rd_addr = {i_rd_line, i_rd_word};

    // Store one refill word per write strobe.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[w_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[w_rd_addr];

endmodule

// File: rtl/icache_direct.sv
// Direct-mapped read-only instruction cache. Hits are answered in the same
// cycle; a miss raises stall and refills the whole line from a word-serial
// memory port. Optional hit/miss counters: define ICACHE_STATS_EN.
module icache_direct
    import icache_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int NUM_LINES      = 16,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_req,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic                  stall,
    input  logic                  flush,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_rvalid,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [31:0]           hit_count,
    output logic [31:0]           miss_count
);

    localparam int OFF_BITS = off_bits(WORDS_PER_LINE);
    localparam int IDX_BITS = idx_bits(NUM_LINES);
    localparam int TAG_BITS = tag_bits(ADDR_WIDTH, NUM_LINES, WORDS_PER_LINE);
    localparam int LINE_LSB = OFF_BITS + 2;
    localparam int TAG_LSB  = LINE_LSB + IDX_BITS;
    localparam logic [OFF_BITS-1:0] LAST_BEAT = OFF_BITS'(WORDS_PER_LINE - 1);

    state_e                  r_state;
    logic [NUM_LINES-1:0]    r_valid;
    logic [TAG_BITS-1:0]     r_tags [NUM_LINES];
    logic                    r_mem_req;
    logic [ADDR_WIDTH-1:0]   r_mem_addr;
    logic [OFF_BITS-1:0]     r_beat;
    logic                    r_flushed;

    logic [OFF_BITS-1:0]     w_cpu_off;
    logic [IDX_BITS-1:0]     w_cpu_idx;
    logic [TAG_BITS-1:0]     w_cpu_tag;
    logic [IDX_BITS-1:0]     w_ref_idx;
    logic [TAG_BITS-1:0]     w_ref_tag;
    logic [DATA_WIDTH-1:0]   w_ram_rdata;
    logic                    w_hit;
    logic                    w_stall;
    logic                    w_miss_start;
    logic                    w_beat_we;
    logic                    w_last_beat;
    logic                    w_unused_byte_bits;

    // Split the fetch address; the latched refill address carries its own
    // index and tag so a wandering cpu_addr cannot corrupt a burst.
    assign w_cpu_off          = cpu_addr[LINE_LSB-1:2];
    assign w_cpu_idx          = cpu_addr[TAG_LSB-1:LINE_LSB];
    assign w_cpu_tag          = cpu_addr[ADDR_WIDTH-1:TAG_LSB];
    assign w_ref_idx          = r_mem_addr[TAG_LSB-1:LINE_LSB];
    assign w_ref_tag          = r_mem_addr[ADDR_WIDTH-1:TAG_LSB];
    assign w_unused_byte_bits = ^cpu_addr[1:0];

    // Lookup and refill strobes; a flush in the lookup cycle forces a miss.
    always_comb begin
        w_hit        = 1'b0;
        w_stall      = 1'b0;
        w_miss_start = 1'b0;
        w_beat_we    = 1'b0;
        w_last_beat  = 1'b0;
        case (r_state)
            IDLE: begin
                if (cpu_req && !flush && r_valid[w_cpu_idx] &&
                    (r_tags[w_cpu_idx] == w_cpu_tag)) begin
                    w_hit = 1'b1;
                end else begin
                    w_hit = 1'b0;
                end
                if (cpu_req && !w_hit) begin
                    w_stall      = 1'b1;
                    w_miss_start = 1'b1;
                end else begin
                    w_stall      = 1'b0;
                    w_miss_start = 1'b0;
                end
            end
            REFILL: begin
                w_stall     = 1'b1;
                w_beat_we   = mem_rvalid;
                w_last_beat = mem_rvalid && (r_beat == LAST_BEAT);
            end
            default: begin
                w_stall = 1'b0;
            end
        endcase
    end

    // Controller: miss capture, beat counting, valid bookkeeping, flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_valid    <= {NUM_LINES{1'b0}};
            r_mem_req  <= 1'b0;
            r_mem_addr <= {ADDR_WIDTH{1'b0}};
            r_beat     <= {OFF_BITS{1'b0}};
            r_flushed  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (flush) begin
                        r_valid <= {NUM_LINES{1'b0}};
                    end
                    if (w_miss_start) begin
                        r_state    <= REFILL;
                        r_mem_req  <= 1'b1;
                        r_mem_addr <= {cpu_addr[ADDR_WIDTH-1:LINE_LSB],
                                       {LINE_LSB{1'b0}}};
                        r_beat     <= {OFF_BITS{1'b0}};
                        r_flushed  <= 1'b0;
                    end
                end
                REFILL: begin
                    // A flush anywhere in the burst keeps the new line invalid.
                    if (flush) begin
                        r_valid <= {NUM_LINES{1'b0}};
                    end else if (w_last_beat && !r_flushed) begin
                        r_valid[w_ref_idx] <= 1'b1;
                    end
                    if (w_last_beat) begin
                        r_state   <= IDLE;
                        r_mem_req <= 1'b0;
                        r_beat    <= {OFF_BITS{1'b0}};
                        r_flushed <= 1'b0;
                    end else begin
                        if (w_beat_we) begin
                            r_beat <= r_beat + {{(OFF_BITS-1){1'b0}}, 1'b1};
                        end
                        if (flush) begin
                            r_flushed <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_mem_req <= 1'b0;
                end
            endcase
        end
    end

    // Tag array has no reset; the tag is committed with the last beat.
    always_ff @(posedge clk) begin
        if (w_last_beat) begin
            r_tags[w_ref_idx] <= w_ref_tag;
        end
    end

    icache_data_ram #(
        .DATA_WIDTH     (DATA_WIDTH),
        .NUM_LINES      (NUM_LINES),
        .WORDS_PER_LINE (WORDS_PER_LINE)
    ) u_data_ram (
        .clk       (clk),
        .i_we      (w_beat_we),
        .i_wr_line (w_ref_idx),
        .i_wr_word (r_beat),
        .i_wr_data (mem_rdata),
        .i_rd_line (w_cpu_idx),
        .i_rd_word (w_cpu_off),
        .o_rd_data (w_ram_rdata)
    );

    assign cpu_rdata = w_hit ? w_ram_rdata : {DATA_WIDTH{1'b0}};
    assign stall     = w_stall;
    assign mem_req   = r_mem_req;
    assign mem_addr  = r_mem_addr;

`ifdef ICACHE_STATS_EN
    logic [31:0] r_hit_count;
    logic [31:0] r_miss_count;

    // Free-running hit/miss statistics, wrapping naturally at 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hit_count  <= 32'd0;
            r_miss_count <= 32'd0;
        end else begin
            if (w_hit) begin
                r_hit_count <= r_hit_count + 32'd1;
            end
            if (w_miss_start) begin
                r_miss_count <= r_miss_count + 32'd1;
            end
        end
    end

    assign hit_count  = r_hit_count;
    assign miss_count = r_miss_count;
`else
    assign hit_count  = 32'd0;
    assign miss_count = 32'd0;
`endif

endmodule

// File: tb/tb_icache_direct.sv
// Directed bench for icache_direct: expected fetch words are queued when a
// fetch is issued and compared when the cache releases stall.
module tb_icache_direct;

`ifdef ICACHE_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        cpu_req;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_rdata;
    logic        stall;
    logic        flush;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    int          n_tests;
    int          n_fail;
    int          m_hit;
    int          m_miss;
    logic [31:0] sb [$];

    icache_direct dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_req    (cpu_req),
        .cpu_addr   (cpu_addr),
        .cpu_rdata  (cpu_rdata),
        .stall      (stall),
        .flush      (flush),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_stats(input string tag);
        chk({tag, "_hits"},   hit_count,  STATS ? 32'(m_hit)  : 32'd0);
        chk({tag, "_misses"}, miss_count, STATS ? 32'(m_miss) : 32'd0);
    endtask

    // Memory side: one beat per entry, preceded by gaps[i] idle cycles.
    task automatic burst(input logic [31:0] w0, input logic [31:0] w1,
                         input logic [31:0] w2, input logic [31:0] w3,
                         input int g0, input int g1, input int g2, input int g3,
                         input int flush_at);
        logic [31:0] w [4];
        int          g [4];
        w = '{w0, w1, w2, w3};
        g = '{g0, g1, g2, g3};
        for (int i = 0; i < 4; i++) begin
            for (int k = 0; k < g[i]; k++) begin
                mem_rvalid = 1'b0;
                flush      = 1'b0;
                #1;
                chk("gap_stall", {31'd0, stall}, 32'd1);
                chk("gap_mem_req", {31'd0, mem_req}, 32'd1);
                @(negedge clk);
                #1;
            end
            mem_rvalid = 1'b1;
            mem_rdata  = w[i];
            flush      = (i == flush_at);
            #1;
            chk("beat_stall", {31'd0, stall}, 32'd1);
            @(negedge clk);
            #1;
        end
        mem_rvalid = 1'b0;
        mem_rdata  = 32'd0;
        flush      = 1'b0;
    endtask

    // Full miss: issue fetch, check refill request, feed line, check retry hit.
    task automatic do_miss(input logic [31:0] addr, input logic [31:0] base,
                           input logic [31:0] w0, input logic [31:0] w1,
                           input logic [31:0] w2, input logic [31:0] w3,
                           input int g0, input int g1, input int g2, input int g3,
                           input logic [31:0] exp_word, input logic flush_first);
        cpu_req  = 1'b1;
        cpu_addr = addr;
        flush    = flush_first;
        #1;
        chk("miss_stall", {31'd0, stall}, 32'd1);
        chk("miss_rdata_zero", cpu_rdata, 32'd0);
        chk("miss_mem_req_pre", {31'd0, mem_req}, 32'd0);
        sb.push_back(exp_word);
        @(negedge clk);
        flush = 1'b0;
        m_miss++;
        #1;
        chk("refill_mem_req", {31'd0, mem_req}, 32'd1);
        chk("refill_mem_addr", mem_addr, base);
        burst(w0, w1, w2, w3, g0, g1, g2, g3, -1);
        chk("done_stall", {31'd0, stall}, 32'd0);
        chk("done_mem_req", {31'd0, mem_req}, 32'd0);
        chk("done_rdata", cpu_rdata, sb.pop_front());
        @(negedge clk);
        m_hit++;
        #1;
    endtask

    task automatic do_hit(input logic [31:0] addr, input logic [31:0] exp_word);
        cpu_req  = 1'b1;
        cpu_addr = addr;
        sb.push_back(exp_word);
        #1;
        chk("hit_stall", {31'd0, stall}, 32'd0);
        chk("hit_mem_req", {31'd0, mem_req}, 32'd0);
        chk("hit_rdata", cpu_rdata, sb.pop_front());
        @(negedge clk);
        m_hit++;
        #1;
    endtask

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        m_hit      = 0;
        m_miss     = 0;
        rst        = 1'b1;
        cpu_req    = 1'b0;
        cpu_addr   = 32'd0;
        flush      = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'd0;

        // Reset state.
        repeat (2) @(negedge clk);
        #1;
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_rdata", cpu_rdata, 32'd0);
        chk_stats("rst");
        rst = 1'b0;
        @(negedge clk);
        #1;

        // Cold miss then hits in the same line.
        do_miss(32'h0000_0000, 32'h0000_0000, 32'h11, 32'h22, 32'h33, 32'h44,
                0, 0, 0, 0, 32'h11, 1'b0);
        chk_stats("cold");
        do_hit(32'h0000_000C, 32'h44);
        do_hit(32'h0000_0006, 32'h22);
        chk_stats("hits");

        // Idle request: no stall, zero data.
        cpu_req = 1'b0;
        #1;
        chk("idle_stall", {31'd0, stall}, 32'd0);
        chk("idle_rdata", cpu_rdata, 32'd0);
        @(negedge clk);
        #1;

        // Conflict at index 0, then the original line misses again.
        do_miss(32'h0000_0100, 32'h0000_0100, 32'hA0, 32'hA1, 32'hA2, 32'hA3,
                0, 0, 0, 0, 32'hA0, 1'b0);
        do_miss(32'h0000_0008, 32'h0000_0000, 32'h11, 32'h22, 32'h33, 32'h44,
                0, 0, 0, 0, 32'h33, 1'b0);
        chk_stats("conflict");

        // Gapped burst: rvalid 1,0,0,1,0,1,1.
        do_miss(32'h0000_0024, 32'h0000_0020, 32'hB0, 32'hB1, 32'hB2, 32'hB3,
                0, 2, 1, 0, 32'hB1, 1'b0);
        do_hit(32'h0000_0020, 32'hB0);
        do_hit(32'h0000_0028, 32'hB2);
        do_hit(32'h0000_002C, 32'hB3);

        // Reset after two beats of a refill.
        cpu_req  = 1'b1;
        cpu_addr = 32'h0000_0030;
        @(negedge clk);
        #1;
        chk("rst_mid_mem_req_before", {31'd0, mem_req}, 32'd1);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h77;
        @(negedge clk);
        mem_rdata  = 32'h78;
        @(negedge clk);
        #1;
        rst        = 1'b1;
        mem_rvalid = 1'b0;
        cpu_req    = 1'b0;
        @(negedge clk);
        #1;
        m_hit  = 0;
        m_miss = 0;
        chk("rst_mid_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_mid_stall", {31'd0, stall}, 32'd0);
        chk("rst_mid_mem_addr", mem_addr, 32'd0);
        chk_stats("rst_mid");
        rst = 1'b0;
        @(negedge clk);
        #1;
        do_miss(32'h0000_0000, 32'h0000_0000, 32'hC0, 32'hC1, 32'hC2, 32'hC3,
                0, 0, 0, 0, 32'hC0, 1'b0);

        // Flush in the lookup cycle of a resident line forces a refill.
        do_miss(32'h0000_0004, 32'h0000_0000, 32'hE0, 32'hE1, 32'hE2, 32'hE3,
                1, 0, 0, 0, 32'hE1, 1'b1);

        // Flush during a refill: burst completes, line stays invalid.
        cpu_req  = 1'b1;
        cpu_addr = 32'h0000_0054;
        #1;
        chk("flush_ref_stall", {31'd0, stall}, 32'd1);
        @(negedge clk);
        m_miss++;
        #1;
        chk("flush_ref_mem_addr", mem_addr, 32'h0000_0050);
        burst(32'hF0, 32'hF1, 32'hF2, 32'hF3, 0, 1, 0, 0, 1);
        chk("flush_retry_stall", {31'd0, stall}, 32'd1);
        chk("flush_retry_rdata", cpu_rdata, 32'd0);
        chk("flush_retry_mem_req", {31'd0, mem_req}, 32'd0);
        do_miss(32'h0000_0054, 32'h0000_0050, 32'h90, 32'h91, 32'h92, 32'h93,
                0, 0, 0, 0, 32'h91, 1'b0);
        // Flush also dropped the line at index 0.
        do_miss(32'h0000_0000, 32'h0000_0000, 32'hD0, 32'hD1, 32'hD2, 32'hD3,
                0, 0, 0, 0, 32'hD0, 1'b0);
        chk_stats("final");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/icache_direct.md
Name: icache_direct

Overview:
Direct-mapped, read-only instruction cache between the fetch stage's instruction port and a word-serial main-memory read port.
- Hits return the instruction combinationally in the same cycle, preserving single-cycle fetch.
- Misses assert stall and refill one whole line through a valid-qualified burst.
- The pipeline holds PC and the F/D register while stall is high.

Parameters:
DATA_WIDTH, 32, instruction/word width in bits
ADDR_WIDTH, 32, byte address width
NUM_LINES, 16, number of cache lines (power of two, >=2)
WORDS_PER_LINE, 4, words per line (power of two, >=2)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
cpu_req  in  1  fetch wants an instruction this cycle
cpu_addr  in  ADDR_WIDTH  byte address (PC); bits [1:0] ignored
cpu_rdata  out  DATA_WIDTH  instruction; valid when cpu_req && !stall
stall  out  1  miss in progress; fetch must hold cpu_addr
flush  in  1  invalidate all lines (fence.i)
mem_req  out  1  refill request, held high for the whole burst
mem_addr  out  ADDR_WIDTH  line-aligned refill base address, stable while mem_req
mem_rvalid  in  1  one refill word is present on mem_rdata
mem_rdata  in  DATA_WIDTH  refill word, delivered in ascending order
hit_count  out  32  hits counted (ICACHE_STATS_EN)
miss_count  out  32  misses counted (ICACHE_STATS_EN)

Behaviour:
- Address split: word offset = cpu_addr[OFF+1:2], OFF = log2(WORDS_PER_LINE); index = next log2(NUM_LINES) bits; tag = remaining upper bits.
- Storage: valid bit per line in flops; tag and data arrays have no reset.
- Reset values: valid[] = 0, state = IDLE, mem_req = 0, mem_addr = 0, beat counter = 0, counters = 0.
- cpu_rdata = 0 when !cpu_req or !hit.
- FSM IDLE:
  - hit = cpu_req && valid[idx] && tag match.
  - On hit: cpu_rdata = data[idx][off] combinationally; stall = 0.
  - cpu_req && !hit: stall = 1 combinationally; latch line base address and tag; next state REFILL.
  - !cpu_req: stall = 0; no action.
- FSM REFILL:
  - mem_req = 1, stall = 1.
  - On each mem_rvalid: write mem_rdata to data[idx][beat]; beat++.
  - Beat counter advances only on mem_rvalid; gaps between beats are legal.
  - On the last beat (beat == WORDS_PER_LINE-1 && mem_rvalid): write the tag, set valid[idx], clear beat, go to IDLE.
  - mem_req deasserts the cycle after the last beat.
- Latency: first-word-ready timing is set by memory. Stall drops the cycle after the last beat; the retried lookup then hits.
- Refill latency is WORDS_PER_LINE + memory latency + 1 cycles minimum.
- cpu_addr changing during REFILL is a protocol violation; the latched address governs.
- flush:
  - In IDLE: all valid bits clear next edge; a lookup in the same cycle is treated as a miss.
  - In REFILL: valid bits clear, the burst completes, the line is written but valid is not set. Return to IDLE; the retry misses again.
- Reset mid-refill: mem_req = 0 next cycle, all valid bits cleared, beat counter = 0. Memory-side burst abandonment is the memory model's responsibility.
- Conflict: a new tag at an occupied index overwrites that line.

Optional Feature:
ICACHE_STATS_EN
- Defined: hit_count increments on each IDLE cycle with hit; miss_count increments on each IDLE→REFILL transition. Both wrap at 2^32 and clear on rst.
- Undefined: both ports tied to 0; no counter flops.

Decomposition:
- Package icache_pkg:
  - state enum {IDLE, REFILL};
  - width helper localparams/functions for OFF_BITS, IDX_BITS, TAG_BITS;
  - address-split typedef struct packed {tag, idx, off, byte}.
- Sub-module icache_data_ram: NUM_LINES×WORDS_PER_LINE words, async read, sync single-word write (line, word, data, we). Valid/tag stay in the parent.

Test Plan:
(NUM_LINES=16, WORDS_PER_LINE=4; index = addr[7:4], off = addr[3:2], tag = addr[31:8].)
1. Cold miss: rst, then cpu_req=1, addr 0x00000000 → stall=1 same cycle; mem_req=1, mem_addr=0x0 next cycle. Feed rvalid beats 0x11,0x22,0x33,0x44 → stall=0 the cycle after the 4th beat, cpu_rdata=0x11, miss_count=1.
2. Hit: addr 0x0000000C after fill → cpu_rdata=0x44, stall=0, mem_req stays 0, hit_count increments.
3. Conflict: addr 0x00000100 → miss, mem_addr=0x100, refill with 0xA0..0xA3 → rdata 0xA0. Then addr 0x0 misses again.
4. Gapped burst: rvalid pattern 1,0,0,1,0,1,1 → exactly 4 words written in order; stall drops only after the 4th valid beat.
5. Reset mid-refill after 2 beats → mem_req=0 next cycle, stall=0. Next access to 0x0 is a miss with a full 4-beat refill.
6. Flush during refill → burst completes, valid not set, retry re-issues mem_req with the same mem_addr.
